// File: rtl/wb_arb_pkg.sv
// Shared types for the regfile write-port arbiter.
// Default widths, queued-entry layout and grant sources.
package wb_arb_pkg;
  localparam int WB_DW = 32;
  localparam int WB_AW = 5;

  typedef struct packed {
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO,
    GNT_BYPASS
  } grant_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle between WB stage, long-latency producer,
// regfile write port and hazard unit.
interface wb_port_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW
);
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic            ll_valid;
  logic [AW-1:0]   ll_rd;
  logic [DW-1:0]   ll_data;
  logic            ll_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [2**AW-1:0] pending_mask;
  logic            stall_req;

  modport master (
    output wb_we, wb_rd, wb_data,
    output ll_valid, ll_rd, ll_data,
    input  ll_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  pending_mask, stall_req
  );

  modport slave (
    input  wb_we, wb_rd, wb_data,
    input  ll_valid, ll_rd, ll_data,
    output ll_ready,
    output rf_we, rf_waddr, rf_wdata,
    output pending_mask, stall_req
  );
endinterface

// File: rtl/wb_arb_fifo.sv
// Small sync FIFO for long-latency results; exports
// per-entry rd and valid so the owner can build a mask.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_rd,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_rd,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic [AW-1:0] entry_rd [DEPTH],
  output logic [DEPTH-1:0] entry_vld
);
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [AW-1:0] rd_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr]   <= push_rd;
      data_q[wptr] <= push_data;
    end
  end

  assign head_rd   = rd_q[rptr];
  assign head_data = data_q[rptr];
  assign empty     = (count == '0);
  assign entry_rd  = rd_q;

  // Slot is live when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    logic [PW-1:0] offs;
    assign offs         = PW'(g) - rptr;
    assign entry_vld[g] = ({1'b0, offs} < count);
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: WB stage wins, long-latency results queue.
// Define WBARB_BYPASS_EN for same-cycle write of ll results on an idle port.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DW         = WB_DW,
  parameter int AW         = WB_AW,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  localparam int CW        = $clog2(DEPTH) + 1,
  localparam int AGW       = $clog2(STARVE_MAX + 1)
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);
  logic          pipe_claim;
  logic          ll_take;
  logic          push;
  logic          pop;
  logic          empty;
  logic [CW-1:0] count;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;
  logic [AW-1:0] entry_rd [DEPTH];
  logic [DEPTH-1:0] entry_vld;
  logic [AGW-1:0] age;
  logic          stall_q;
  logic [2**AW-1:0] mask;
  grant_e        grant;

  assign pipe_claim   = bus.wb_we & (|bus.wb_rd);
  assign ll_take      = bus.ll_valid & (|bus.ll_rd);
  assign bus.ll_ready = ~reset & (count < CW'(DEPTH));

  always_comb begin
    grant = GNT_NONE;
    unique case (1'b1)
      reset:                         grant = GNT_NONE;
      ~reset & pipe_claim:           grant = GNT_PIPE;
      ~reset & ~pipe_claim & ~empty: grant = GNT_FIFO;
`ifdef WBARB_BYPASS_EN
      ~reset & ~pipe_claim & empty & ll_take:
                                     grant = GNT_BYPASS;
`endif
      default:                       grant = GNT_NONE;
    endcase
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    unique case (grant)
      GNT_PIPE: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wb_rd;
        bus.rf_wdata = bus.wb_data;
      end
      GNT_FIFO: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = head_rd;
        bus.rf_wdata = head_data;
      end
      GNT_BYPASS: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.ll_rd;
        bus.rf_wdata = bus.ll_data;
      end
      default: ;
    endcase
  end

  // r0 results complete the handshake but never occupy a slot.
  assign pop  = (grant == GNT_FIFO);
  assign push = ll_take & bus.ll_ready & (grant != GNT_BYPASS);

  wb_arb_fifo #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (bus.ll_rd),
    .push_data (bus.ll_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (count),
    .empty     (empty),
    .entry_rd  (entry_rd),
    .entry_vld (entry_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age     <= '0;
      stall_q <= 1'b0;
    end else begin
      if (pop || empty)
        age <= '0;
      else if (age != AGW'(STARVE_MAX))
        age <= age + 1'b1;
      stall_q <= ~pop & ~empty & (age == AGW'(STARVE_MAX));
    end
  end

  assign bus.stall_req = stall_q;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (entry_vld[i]) mask[entry_rd[i]] = 1'b1;
  end

  assign bus.pending_mask = mask;
endmodule
